// File: rtl/jk_edge_event_counter_if.sv
// jk_edge_event_counter_if
// Bundles the observed bit, the window commands and the counter status
// between a driver (master) and the edge event counter (slave).
interface jk_edge_event_counter_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             arm;
    logic             clear;
    logic [WIDTH-1:0] thresh;
    logic [WIDTH-1:0] count;
    logic             rise_p;
    logic             fall_p;
    logic             busy;
    logic             hit;
    logic             ovf;

    modport master (
        output din, arm, clear, thresh,
        input  count, rise_p, fall_p, busy, hit, ovf
    );

    modport slave (
        input  din, arm, clear, thresh,
        output count, rise_p, fall_p, busy, hit, ovf
    );
endinterface

// File: rtl/jk_edge_event_counter.sv
// jk_edge_event_counter
// Watches the q output of an upstream JK flip-flop, pulses on its rising
// and falling transitions and counts the selected ones inside an armed
// window until a programmable threshold is reached.
// Build option: define EDGE_COUNTER_SAT_EN to make the counter saturate at
// its maximum instead of wrapping to zero (ovf is set in both builds).
module jk_edge_event_counter #(
    parameter int WIDTH     = 8,
    parameter int EDGE_MODE = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    jk_edge_event_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    logic             din_r;
    logic             din_rr;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             hit;
    logic             ovf;

    logic             rise;
    logic             fall;
    logic             ev;
    logic             at_max;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_next;

    // Edges are decoded purely from the two sample registers so the pulses
    // are clean and last exactly one cycle.
    assign rise = din_r & ~din_rr;
    assign fall = ~din_r & din_rr;

    // Select which transitions count as events for this instance.
    always_comb begin
        ev = 1'b0;
        if (EDGE_MODE == 0) begin
            ev = rise;
        end else if (EDGE_MODE == 1) begin
            ev = fall;
        end else begin
            ev = rise | fall;
        end
    end

    assign at_max    = (count == CNT_MAX);
    assign count_inc = count + WIDTH'(1);

    // Value the counter takes on a qualifying event; at the top it either
    // holds (saturating build) or rolls over to zero (default build).
    always_comb begin
        count_next = count_inc;
`ifdef EDGE_COUNTER_SAT_EN
        if (at_max) begin
            count_next = CNT_MAX;
        end
`else
        count_next = count_inc;
`endif
    end

    // Sample history plus the window FSM; clear beats arm, and arm beats a
    // same-cycle event, so any command discards a pending edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_r  <= 1'b0;
            din_rr <= 1'b0;
            state  <= IDLE;
            count  <= '0;
            busy   <= 1'b0;
            hit    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            din_r  <= bus.din;
            din_rr <= din_r;
            if (bus.clear) begin
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
                hit   <= 1'b0;
                ovf   <= 1'b0;
            end else if (bus.arm) begin
                count <= '0;
                ovf   <= 1'b0;
                if (bus.thresh == '0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    hit   <= 1'b1;
                end else begin
                    state <= COUNTING;
                    busy  <= 1'b1;
                    hit   <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        hit  <= 1'b0;
                    end
                    COUNTING: begin
                        if (ev) begin
                            count <= count_next;
                            if (at_max) begin
                                ovf <= 1'b1;
                            end
                            if (count_next == bus.thresh) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                hit   <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        busy <= 1'b0;
                        hit  <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                        hit   <= 1'b0;
                        ovf   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count  = count;
    assign bus.rise_p = rise;
    assign bus.fall_p = fall;
    assign bus.busy   = busy;
    assign bus.hit    = hit;
    assign bus.ovf    = ovf;

endmodule
